// File: rtl/vi_period_detect_if.sv
// Sample stream interface for vi_period_detect: packed CH1/CH2 ADC words
// with a valid/ready handshake. The source takes the master modport and the
// period detector takes the slave modport.
interface vi_period_detect_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic                        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/vi_period_detect.sv
// vi_period_detect: measures the period of the CH1 ADC waveform in samples.
// CH1 is offset-corrected and registered, then a hysteresis FSM finds rising
// crossings and a sample counter measures the distance between them.
// A period shorter than MIN_PERIOD is treated as noise and ignored. If the
// counter reaches MAX_PERIOD, the block drops lock and re-arms.
// Optional macro VI_PERIOD_AVG_EN: when defined, 2^AVG_LOG2 accepted periods
// are averaged before period_out updates (AVG_LOG2 must be >= 1).
module vi_period_detect #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int COUNT_WIDTH      = 32,
  parameter int HYST             = 64,
  parameter int MIN_PERIOD       = 1000,
  parameter int MAX_PERIOD       = 12500000,
  parameter int AVG_LOG2         = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  vi_period_detect_if.slave             S_AXIS_IN,
  input  logic signed [COUNT_WIDTH-1:0] calib_CH1,
  output logic        [COUNT_WIDTH-1:0] period_out,
  output logic                          period_valid,
  output logic                          locked
);

  localparam int CW = COUNT_WIDTH;
  localparam logic signed [CW-1:0] HYST_POS = CW'(HYST);
  localparam logic signed [CW-1:0] HYST_NEG = -HYST_POS;
  localparam logic        [CW-1:0] MIN_P    = CW'(MIN_PERIOD);
  localparam logic        [CW-1:0] MAX_P    = CW'(MAX_PERIOD);

  typedef enum logic [1:0] {SEEK_LOW, SEEK_HIGH, LOST} state_t;

  // The block never stalls the stream.
  assign S_AXIS_IN.tready = 1'b1;

  // CH2 and the padding bits carry nothing this block needs.
  logic unused_tdata_hi;
  assign unused_tdata_hi = ^S_AXIS_IN.tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH];

  logic signed [CW-1:0] adc_sext;
  logic signed [CW-1:0] samp_d;
  logic signed [CW-1:0] samp_q;
  logic                 samp_vld_q;

  assign adc_sext = {{(CW-ADC_WIDTH){S_AXIS_IN.tdata[ADC_WIDTH-1]}},
                     S_AXIS_IN.tdata[ADC_WIDTH-1:0]};
  assign samp_d   = adc_sext + calib_CH1;

  // Stage 1: register the offset-corrected CH1 sample and its valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q     <= '0;
      samp_vld_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values and the order of statements does not matter.
      samp_vld_q <= S_AXIS_IN.tvalid;
      if (S_AXIS_IN.tvalid) samp_q <= samp_d;
    end
  end

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          started_q;
  logic [CW-1:0] period_q;
  logic          valid_q;
  logic          locked_q;

  logic [CW-1:0] cnt_inc;
  logic          timeout;
  logic          lo_hit;
  logic          hi_hit;

  // cnt_inc is the period length if the current sample is a crossing.
  assign cnt_inc = cnt_q + CW'(1);
  assign timeout = (cnt_inc >= MAX_P);
  assign lo_hit  = (samp_q <= HYST_NEG);
  assign hi_hit  = (samp_q >= HYST_POS);

`ifdef VI_PERIOD_AVG_EN
  logic [CW+AVG_LOG2-1:0] acc_q;
  logic [CW+AVG_LOG2-1:0] acc_sum;
  logic [AVG_LOG2-1:0]    avg_n_q;

  assign acc_sum = acc_q + {{AVG_LOG2{1'b0}}, cnt_inc};
`endif

  // Stage 2: crossing FSM, sample counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEEK_LOW;
      cnt_q     <= '0;
      started_q <= 1'b0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
`ifdef VI_PERIOD_AVG_EN
      acc_q     <= '0;
      avg_n_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (samp_vld_q) begin
        if (state_q == LOST) begin
          state_q <= SEEK_LOW;
          cnt_q   <= '0;
        end else if (timeout) begin
          // Loss of signal beats a coincident crossing; period_q is held.
          state_q   <= LOST;
          cnt_q     <= '0;
          started_q <= 1'b0;
          locked_q  <= 1'b0;
`ifdef VI_PERIOD_AVG_EN
          acc_q     <= '0;
          avg_n_q   <= '0;
`endif
        end else if (state_q == SEEK_LOW) begin
          cnt_q <= cnt_inc;
          if (lo_hit) state_q <= SEEK_HIGH;
        end else if (!hi_hit) begin
          cnt_q <= cnt_inc;
        end else begin
          // Rising crossing.
          state_q <= SEEK_LOW;
          if (!started_q) begin
            started_q <= 1'b1;
            cnt_q     <= '0;
          end else if (cnt_inc < MIN_P) begin
            cnt_q <= cnt_inc;
          end else begin
            cnt_q <= '0;
`ifdef VI_PERIOD_AVG_EN
            if (&avg_n_q) begin
              period_q <= acc_sum[CW+AVG_LOG2-1:AVG_LOG2];
              valid_q  <= 1'b1;
              locked_q <= 1'b1;
              acc_q    <= '0;
              avg_n_q  <= '0;
            end else begin
              acc_q   <= acc_sum;
              avg_n_q <= avg_n_q + AVG_LOG2'(1);
            end
`else
            period_q <= cnt_inc;
            valid_q  <= 1'b1;
            locked_q <= 1'b1;
`endif
          end
        end
      end
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;

endmodule

// File: doc/vi_period_detect.md
VI_PERIOD_DETECT -- requirements
Module: vi_period_detect

Interface
REQ-001 Parameter ADC_WIDTH, default 14, meaning ADC sample width in bits.
REQ-002 Parameter AXIS_TDATA_WIDTH, default 32, meaning input stream width; CH1 occupies tdata[ADC_WIDTH-1:0].
REQ-003 Parameter COUNT_WIDTH, default 32, meaning width of the sample counter and period output.
REQ-004 Parameter HYST, default 64, meaning hysteresis half-band in ADC codes.
REQ-005 Parameter MIN_PERIOD, default 1000, meaning shortest accepted period in samples.
REQ-006 Parameter MAX_PERIOD, default 12500000, meaning sample count that declares loss of signal.
REQ-007 Parameter AVG_LOG2, default 2, meaning log2 of the number of periods averaged.
REQ-008 clk  input  1  single clock for all logic.
REQ-009 rst  input  1  reset, synchronous and active-high.
REQ-010 S_AXIS_IN_tdata  input  AXIS_TDATA_WIDTH  packed CH1/CH2 ADC samples.
REQ-011 S_AXIS_IN_tvalid  input  1  sample valid.
REQ-012 S_AXIS_IN_tready  output  1  constant 1; the block never stalls.
REQ-013 calib_CH1  input  COUNT_WIDTH  signed CH1 offset correction.
REQ-014 period_out  output  COUNT_WIDTH  measured period in samples; drives the downstream rms counter_in.
REQ-015 period_valid  output  1  one-cycle pulse when period_out updates.
REQ-016 locked  output  1  high while a valid periodic signal is tracked.

Function
REQ-017 The block SHALL accept a sample on every cycle in which tvalid=1; cycles with tvalid=0 SHALL NOT change counters or state.
REQ-018 Stage 1 SHALL register d = sign-extended tdata[ADC_WIDTH-1:0] + calib_CH1, COUNT_WIDTH bits, signed.
REQ-019 FSM states: SEEK_LOW, SEEK_HIGH, LOST; SEEK_LOW -> SEEK_HIGH when d <= -HYST; SEEK_HIGH -> SEEK_LOW when d >= +HYST; that sample is a rising crossing.
REQ-020 Sample counter cnt SHALL increment per accepted sample and clear to 0 on each rising crossing sample; period = cnt including the current crossing sample.
REQ-021 The first crossing after reset or LOST SHALL only start cnt; no period is emitted.
REQ-022 A crossing with period < MIN_PERIOD SHALL be ignored: cnt keeps counting, FSM returns to SEEK_LOW, no update.
REQ-023 When cnt reaches MAX_PERIOD the FSM SHALL enter LOST, drop locked, hold period_out, clear cnt, then return to SEEK_LOW on the next accepted sample.
REQ-024 If a crossing and cnt == MAX_PERIOD occur on the same sample, the timeout SHALL win.
REQ-025 period_out and period_valid SHALL update two cycles after the crossing sample's tvalid cycle.
REQ-026 locked SHALL rise with the first period_valid and fall only on LOST or reset.

Reset
REQ-027 On rst=1 at a clk edge: FSM=SEEK_LOW, cnt=0, d=0, period_out=0, period_valid=0, locked=0, accumulator and average count=0.
REQ-028 Reset mid-period SHALL discard the partial measurement; the next crossing is treated as the first.

Configuration
REQ-029 Macro VI_PERIOD_AVG_EN defined: periods SHALL be summed over 2^AVG_LOG2 accepted periods; period_out = sum >> AVG_LOG2, period_valid pulses once per block, and locked rises with the first average.
REQ-030 Macro VI_PERIOD_AVG_EN undefined: every accepted period SHALL drive period_out directly; no accumulator is present.

Verification
REQ-031 Square wave +/-4000, period 1000 samples, tvalid=1 -> from the second crossing onward, period_out=1000, one period_valid pulse per cycle, locked=1.
REQ-032 Same wave with tvalid=0 on every other clk -> period_out=1000 (samples, not clocks).
REQ-033 Inject a +/-200 glitch 50 samples after a crossing -> no update; next period_out=1000.
REQ-034 Drive a constant 0 after lock for MAX_PERIOD samples -> locked=0, period_out holds 1000.
REQ-035 Assert rst for 1 cycle mid-period -> all outputs 0; the first post-reset crossing emits nothing; the next one emits 1000.
REQ-036 With VI_PERIOD_AVG_EN defined, periods 998, 1002, 1000, 1000 -> a single period_valid with period_out=1000.
